// File: rtl/gesture_debounce.sv
// gesture_debounce: temporal filter between the per-frame finger counter and
// the video-enhancement control. A command is issued once the same nonzero
// count has been seen for STABLE_FRAMES consecutive frames. Releasing a held
// gesture starts a cooldown window that masks blob flicker.
// Optional feature macro: GESTURE_REPEAT_EN (auto-repeat every REPEAT_FRAMES
// frames while a gesture stays held).
module gesture_debounce #(
   parameter int unsigned STABLE_FRAMES   = 8,
   parameter int unsigned COOLDOWN_FRAMES = 16,
   parameter int unsigned REPEAT_FRAMES   = 30
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       valid_in,
   input  logic [3:0] count_in,
   output logic [2:0] cmd_out,
   output logic       cmd_valid_out,
   output logic       held_out,
   output logic [1:0] state_out
);

   localparam logic [7:0] STABLE_CNT = 8'(STABLE_FRAMES);
   localparam logic [7:0] COOL_CNT   = 8'(COOLDOWN_FRAMES);
   localparam logic [3:0] MAX_COUNT  = 4'd5;

   typedef enum logic [1:0] {
      ST_TRACK    = 2'd0,
      ST_ISSUED   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   state_t     state, nxt_state;
   logic [2:0] cand, nxt_cand;
   logic [7:0] streak, nxt_streak;
   logic [7:0] cool, nxt_cool;
   logic [2:0] nxt_cmd;
   logic       nxt_cmd_valid;

   logic       count_ok;
   logic       same;
   logic [7:0] streak_inc;
   logic [7:0] cool_inc;

`ifdef GESTURE_REPEAT_EN
   localparam logic [7:0] REPEAT_CNT = 8'(REPEAT_FRAMES);
   logic [7:0] rep, nxt_rep;
   logic [7:0] rep_inc;
`else
   logic unused_rep;
   assign unused_rep = ^8'(REPEAT_FRAMES);
`endif

   // Frame classification helpers
   assign count_ok   = (count_in <= MAX_COUNT);
   assign same       = (count_in == {1'b0, cand});
   assign streak_inc = (streak == 8'hFF) ? streak : streak + 8'd1;
   assign cool_inc   = cool + 8'd1;
`ifdef GESTURE_REPEAT_EN
   assign rep_inc    = rep + 8'd1;
`endif

   // Next-state and next-output decode; only valid frames advance anything
   always_comb begin
      nxt_state     = state;
      nxt_cand      = cand;
      nxt_streak    = streak;
      nxt_cool      = cool;
      nxt_cmd       = cmd_out;
      nxt_cmd_valid = 1'b0;
`ifdef GESTURE_REPEAT_EN
      nxt_rep       = rep;
`endif
      if (valid_in) begin
         case (state)
            ST_TRACK: begin
               if (!count_ok) begin
                  nxt_cand   = 3'd0;
                  nxt_streak = 8'd0;
               end else if (same) begin
                  nxt_streak = streak_inc;
                  // "No hand" (cand 0) only saturates, never issues
                  if (streak_inc == STABLE_CNT && cand != 3'd0) begin
                     nxt_cmd_valid = 1'b1;
                     nxt_cmd       = cand;
                     nxt_state     = ST_ISSUED;
`ifdef GESTURE_REPEAT_EN
                     nxt_rep       = 8'd0;
`endif
                  end
               end else begin
                  nxt_cand   = count_in[2:0];
                  nxt_streak = 8'd1;
               end
            end
            ST_ISSUED: begin
               if (count_ok && same) begin
`ifdef GESTURE_REPEAT_EN
                  if (rep_inc == REPEAT_CNT) begin
                     nxt_cmd_valid = 1'b1;
                     nxt_rep       = 8'd0;
                  end else begin
                     nxt_rep = rep_inc;
                  end
`endif
               end else begin
                  nxt_cool  = 8'd0;
                  nxt_state = ST_COOLDOWN;
                  if (!count_ok) begin
                     nxt_cand   = 3'd0;
                     nxt_streak = 8'd0;
                  end
               end
            end
            ST_COOLDOWN: begin
               nxt_cool = cool_inc;
               // Exit frame seeds tracking with its own count
               if (cool_inc == COOL_CNT) begin
                  nxt_state  = ST_TRACK;
                  nxt_cand   = count_in[2:0];
                  nxt_streak = 8'd1;
               end
               if (!count_ok) begin
                  nxt_cand   = 3'd0;
                  nxt_streak = 8'd0;
               end
            end
            default: begin
               nxt_state  = ST_TRACK;
               nxt_cand   = 3'd0;
               nxt_streak = 8'd0;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= ST_TRACK;
         cand          <= 3'd0;
         streak        <= 8'd0;
         cool          <= 8'd0;
         cmd_out       <= 3'd0;
         cmd_valid_out <= 1'b0;
         held_out      <= 1'b0;
         state_out     <= 2'd0;
`ifdef GESTURE_REPEAT_EN
         rep           <= 8'd0;
`endif
      end else begin
         state         <= nxt_state;
         cand          <= nxt_cand;
         streak        <= nxt_streak;
         cool          <= nxt_cool;
         cmd_out       <= nxt_cmd;
         cmd_valid_out <= nxt_cmd_valid;
         held_out      <= (nxt_state == ST_ISSUED);
         state_out     <= nxt_state;
`ifdef GESTURE_REPEAT_EN
         rep           <= nxt_rep;
`endif
      end
   end

endmodule

// File: tb/tb_gesture_debounce.sv
// Testbench for gesture_debounce: directed test-plan scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_gesture_debounce;

   localparam int unsigned STABLE = 4;
   localparam int unsigned COOL   = 3;
   localparam int unsigned REP    = 5;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       valid_in;
   logic [3:0] count_in;
   logic [2:0] cmd_out;
   logic       cmd_valid_out;
   logic       held_out;
   logic [1:0] state_out;

   int n_assert = 0;
   int n_fail   = 0;
   int n_pulse  = 0;

   // Reference model: mode 0 = tracking, 1 = held, 2 = cooldown
   int m_mode, m_cand, m_streak, m_cool, m_rep, m_cmd, m_pulse;

   always #5 clk_in = ~clk_in;

   gesture_debounce #(
      .STABLE_FRAMES  (STABLE),
      .COOLDOWN_FRAMES(COOL),
      .REPEAT_FRAMES  (REP)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .valid_in     (valid_in),
      .count_in     (count_in),
      .cmd_out      (cmd_out),
      .cmd_valid_out(cmd_valid_out),
      .held_out     (held_out),
      .state_out    (state_out)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cand = 0; m_streak = 0; m_cool = 0; m_rep = 0;
      m_cmd = 0; m_pulse = 0;
   endtask

   task automatic model_frame(input int c);
      bit bad;
      bad     = (c > 5);
      m_pulse = 0;
      if (m_mode == 1) begin
         if (!bad && c == m_cand) begin
`ifdef GESTURE_REPEAT_EN
            m_rep++;
            if (m_rep == int'(REP)) begin
               m_pulse = 1;
               m_rep   = 0;
            end
`endif
         end else begin
            m_mode = 2;
            m_cool = 0;
         end
      end else if (m_mode == 2) begin
         m_cool++;
         if (m_cool == int'(COOL)) begin
            m_mode   = 0;
            m_cand   = bad ? 0 : c;
            m_streak = bad ? 0 : 1;
         end else if (bad) begin
            m_cand   = 0;
            m_streak = 0;
         end
      end else begin
         if (bad) begin
            m_cand   = 0;
            m_streak = 0;
         end else if (c == m_cand) begin
            if (m_streak < 255) m_streak++;
            if (m_streak == int'(STABLE) && m_cand != 0) begin
               m_pulse = 1;
               m_cmd   = m_cand;
               m_mode  = 1;
               m_rep   = 0;
            end
         end else begin
            m_cand   = c;
            m_streak = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("cmd_valid", 8'(cmd_valid_out), 8'(m_pulse));
      chk("cmd",       8'(cmd_out),       8'(m_cmd));
      chk("held",      8'(held_out),      8'(m_mode == 1));
      chk("state",     8'(state_out),     8'(m_mode));
      if (cmd_valid_out === 1'b1) n_pulse++;
   endtask

   // One clock cycle starting and ending at a falling edge
   task automatic step(input logic v, input logic [3:0] c);
      valid_in = v;
      count_in = c;
      @(negedge clk_in);
      if (v) model_frame(int'(c));
      else   m_pulse = 0;
      check_outputs();
   endtask

   task automatic frames(input logic [3:0] c, input int n);
      repeat (n) step(1'b1, c);
   endtask

   task automatic do_reset(input logic v, input logic [3:0] c);
      rst_in   = 1'b1;
      valid_in = v;
      count_in = c;
      @(negedge clk_in);
      rst_in   = 1'b0;
      valid_in = 1'b0;
      model_reset();
      check_outputs();
   endtask

   initial begin
      logic [3:0] last;
      int         exp_rep_pulses;

      rst_in   = 1'b1;
      valid_in = 1'b0;
      count_in = 4'd0;
      model_reset();
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      check_outputs();

      // Stable issue
      frames(4'd3, 3);
      chk("stable_early", 8'(cmd_valid_out), 8'd0);
      step(1'b1, 4'd3);
      chk("stable_pulse", 8'(cmd_valid_out), 8'd1);
      chk("stable_cmd",   8'(cmd_out),       8'd3);
      chk("stable_held",  8'(held_out),      8'd1);
      step(1'b0, 4'd0);
      chk("stable_one_cycle", 8'(cmd_valid_out), 8'd0);

      // Flicker rejection
      do_reset(1'b0, 4'd0);
      n_pulse = 0;
      frames(4'd2, 3); step(1'b1, 4'd4); frames(4'd2, 3);
      chk("flicker_none", 8'(n_pulse), 8'd0);
      step(1'b1, 4'd2);
      chk("flicker_pulse", 8'(cmd_valid_out), 8'd1);
      chk("flicker_cmd",   8'(cmd_out),       8'd2);

      // Release and cooldown
      do_reset(1'b0, 4'd0);
      frames(4'd5, 4);
      chk("release_cmd5", 8'(cmd_out), 8'd5);
      n_pulse = 0;
      frames(4'd1, 6);
      chk("cooldown_none", 8'(n_pulse), 8'd0);
      step(1'b1, 4'd1);
      chk("post_cool_pulse", 8'(cmd_valid_out), 8'd1);
      chk("post_cool_cmd",   8'(cmd_out),       8'd1);

      // No hand and invalid values
      do_reset(1'b0, 4'd0);
      n_pulse = 0;
      frames(4'd0, 10);
      chk("nohand_none",  8'(n_pulse),   8'd0);
      chk("nohand_state", 8'(state_out), 8'd0);
      frames(4'd4, 2); step(1'b1, 4'd9); frames(4'd4, 2);
      chk("invalid_none", 8'(n_pulse), 8'd0);
      step(1'b1, 4'd4);
      chk("invalid_wait", 8'(cmd_valid_out), 8'd0);
      step(1'b1, 4'd4);
      chk("invalid_pulse", 8'(cmd_valid_out), 8'd1);
      chk("invalid_cmd",   8'(cmd_out),       8'd4);

      // Reset mid-streak, coinciding with the completing frame
      do_reset(1'b0, 4'd0);
      frames(4'd3, 3);
      do_reset(1'b1, 4'd3);
      chk("rst_cmd_valid", 8'(cmd_valid_out), 8'd0);
      chk("rst_cmd",       8'(cmd_out),       8'd0);
      chk("rst_held",      8'(held_out),      8'd0);
      chk("rst_state",     8'(state_out),     8'd0);
      n_pulse = 0;
      step(1'b1, 4'd3);
      chk("rst_no_pulse", 8'(n_pulse), 8'd0);

      // Long hold: auto-repeat only with the feature enabled
      do_reset(1'b0, 4'd0);
      n_pulse = 0;
      frames(4'd2, 14);
`ifdef GESTURE_REPEAT_EN
      exp_rep_pulses = 3;
`else
      exp_rep_pulses = 1;
`endif
      chk("hold_pulses", 8'(n_pulse), 8'(exp_rep_pulses));

      // Randomized frames with gaps, holds, invalid values and rare resets
      do_reset(1'b0, 4'd0);
      last = 4'd0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)));
         end else if ($urandom_range(0, 99) < 20) begin
            step(1'b0, 4'($urandom_range(0, 15)));
         end else begin
            if ($urandom_range(0, 99) < 25) begin
               if ($urandom_range(0, 99) < 12) last = 4'($urandom_range(6, 15));
               else                            last = 4'($urandom_range(0, 5));
            end
            step(1'b1, last);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gesture_debounce.md
# gesture_debounce

Temporal filter between the per-frame finger-count stage and the video-enhancement control logic. Accepts one finger count (0–5) per frame and issues a one-cycle command pulse only after the same nonzero count has persisted for `STABLE_FRAMES` consecutive frames. After a held gesture is released, the block enters a cooldown window that suppresses spurious re-triggers caused by blob flicker.

## Interface
- `STABLE_FRAMES`, default 8: consecutive identical frames required before a command is issued; legal range 2–255.
- `COOLDOWN_FRAMES`, default 16: frames ignored after a held gesture is released; legal range 1–255.
- `REPEAT_FRAMES`, default 30: auto-repeat period in frames; used only when `GESTURE_REPEAT_EN` is defined.

Ports:
- `clk_in`  input  1: system clock; the block's only clock.
- `rst_in`  input  1: synchronous, active-high reset.
- `valid_in`  input  1: one-cycle pulse, one per frame; qualifies `count_in`.
- `count_in`  input  4: finger count for the frame; values 0–5 are meaningful.
- `cmd_out`  output  3: issued gesture (1–5); holds its value between pulses.
- `cmd_valid_out`  output  1: one-cycle pulse; `cmd_out` is valid in the same cycle.
- `held_out`  output  1: high while in ISSUED.
- `state_out`  output  2: current state (TRACK=0, ISSUED=1, COOLDOWN=2), for debug.

## Operation
- Registers:
  - `cand`: candidate count, 3 bits.
  - `streak`: saturating frame counter, 8 bits.
  - `cool`: cooldown counter, 8 bits.
  - `rep`: repeat counter, 8 bits.
- Only cycles with `valid_in`=1 advance any state or counter. All other cycles hold state.
- A `count_in` value greater than 5 is invalid. It sets `cand`=0 and `streak`=0, and the state is unchanged except as described under ISSUED.
- TRACK:
  - If `count_in`==`cand`, then `streak`++ (saturating).
  - Otherwise `cand`←`count_in` and `streak`←1.
  - When the frame makes `streak` equal `STABLE_FRAMES` and `cand`≠0:
    - pulse `cmd_valid_out`;
    - set `cmd_out`←`cand`;
    - go to ISSUED.
  - `cand`=0 ("no hand") never issues; `streak` saturates and the state stays TRACK.
- ISSUED:
  - A frame with `count_in`==`cand` stays in ISSUED.
  - Any other frame, including an invalid value or 0, sets `cool`←0 and goes to COOLDOWN.
- COOLDOWN:
  - Frame contents are ignored; each frame increments `cool`.
  - On the frame where `cool` reaches `COOLDOWN_FRAMES`:
    - go to TRACK;
    - set `cand`←`count_in` of that frame;
    - set `streak`←1.
- Edge-triggered: exactly one command per continuous hold, unless `GESTURE_REPEAT_EN` is defined.

## Timing
- Reset values:
  - `cmd_out`=0, `cmd_valid_out`=0, `held_out`=0, `state_out`=0 (TRACK).
  - `cand`=0, `streak`=0, `cool`=0, `rep`=0.
- Latency: `cmd_valid_out` rises in the cycle after the `valid_in` cycle that completes the streak. It is high for exactly one cycle.
- `held_out` and `state_out` change in the same cycle as `cmd_valid_out`.
- Back-to-back `valid_in` on consecutive cycles is supported at full rate. No frame is dropped.
- Reset asserted mid-streak or mid-cooldown returns every register to its reset value on the next edge. A pending pulse is not emitted.
- Reset has priority over `valid_in` in the same cycle.

## Configuration
- `GESTURE_REPEAT_EN` defined:
  - In ISSUED, every frame with `count_in`==`cand` increments `rep`.
  - When `rep` reaches `REPEAT_FRAMES`, re-pulse `cmd_valid_out` with the same `cmd_out` and clear `rep`.
  - `rep` is cleared on entry to ISSUED.
- `GESTURE_REPEAT_EN` undefined:
  - `rep` and its logic are absent.
  - A hold produces a single pulse regardless of duration.

## Test plan
Parameters for all scenarios: `STABLE_FRAMES`=4, `COOLDOWN_FRAMES`=3, `REPEAT_FRAMES`=5.

- **Stable issue.** Frames 3,3,3,3 → one `cmd_valid_out` pulse with `cmd_out`=3 the cycle after the 4th frame; `held_out`=1.
- **Flicker rejection.** Frames 2,2,2,4,2,2,2 → no pulse. Then one more 2 → pulse with `cmd_out`=2.
- **Release and cooldown.** After issuing 5, frames 1,1,1 (cooldown), then 1,1,1,1 → exactly one pulse with `cmd_out`=1, on the 4th post-cooldown frame. No pulse during the cooldown frames.
- **No hand and invalid values.** 10 frames of 0 → no pulse, state stays TRACK. Frames 4,4,9,4,4 → streak resets at 9; no pulse until two more 4s.
- **Reset mid-streak.** Frames 3,3,3, assert `rst_in` for 1 cycle, then 3 → no pulse. All outputs are 0 the cycle after reset.
- **Repeat (`GESTURE_REPEAT_EN`).** Hold 2 for 14 frames → pulses after frames 4, 9 and 14. Without the macro → only the pulse after frame 4.
